// File: rtl/mat_mul_seq.sv
// mat_mul_seq: latches an I x J lhs and a J x K rhs, drives one external dot unit per output element.
// Optional job cycle counter: define MAT_MUL_SEQ_CYCLE_CNT_EN.
module mat_mul_seq #(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    parameter int I          = 4,
    parameter int J          = 4,
    parameter int K          = 4,
    parameter int DOT_LAT    = 0,
    localparam int W         = 1 + EXP_WIDTH + MANT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [I*J*W-1:0] i_lhs,
    input  logic [J*K*W-1:0] i_rhs,
    output logic             o_dot_req,
    output logic [J*W-1:0]   o_dot_lhs,
    output logic [J*W-1:0]   o_dot_rhs,
    input  logic [W-1:0]     i_dot_res,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [I*K*W-1:0] o_out,
    output logic [31:0]      o_cycles
);
    localparam int IW = (I > 1) ? $clog2(I) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(I - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_dot_req;
    logic               r_out_valid;
    logic [I*J*W-1:0]   r_lhs;
    logic [J*K*W-1:0]   r_rhs;
    logic [I*K*W-1:0]   r_out;
    logic [IW-1:0]      r_i;
    logic [KW-1:0]      r_k;

    logic               w_issue_last;
    logic               w_ret_valid;
    logic [IW-1:0]      w_ret_i;
    logic [KW-1:0]      w_ret_k;
    logic               w_ret_last;
    logic [J*W-1:0]     w_dot_lhs;
    logic [J*W-1:0]     w_dot_rhs;

    assign w_issue_last = (r_i == I_LAST) && (r_k == K_LAST);
    assign w_ret_last   = w_ret_valid && (w_ret_i == I_LAST) && (w_ret_k == K_LAST);

    // Row r_i of lhs and column r_k of rhs, forced to zero when nothing is issued.
    always_comb begin
        w_dot_lhs = '0;
        w_dot_rhs = '0;
        if (r_dot_req) begin
            for (int r = 0; r < I; r++) begin
                if (r_i == IW'(r)) begin
                    for (int c = 0; c < J; c++) begin
                        w_dot_lhs[c*W +: W] = r_lhs[(r*J + c)*W +: W];
                    end
                end
            end
            for (int c = 0; c < K; c++) begin
                if (r_k == KW'(c)) begin
                    for (int j = 0; j < J; j++) begin
                        w_dot_rhs[j*W +: W] = r_rhs[(j*K + c)*W +: W];
                    end
                end
            end
        end
    end

    // Issue tracker: the entry leaving the pipe names the element dot_res belongs to.
    generate
        if (DOT_LAT == 0) begin : g_no_lat
            assign w_ret_valid = r_dot_req;
            assign w_ret_i     = r_i;
            assign w_ret_k     = r_k;
        end else begin : g_lat
            logic          r_pv [DOT_LAT];
            logic [IW-1:0] r_pi [DOT_LAT];
            logic [KW-1:0] r_pk [DOT_LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int n = 0; n < DOT_LAT; n++) begin
                        r_pv[n] <= 1'b0;
                        r_pi[n] <= '0;
                        r_pk[n] <= '0;
                    end
                end else begin
                    r_pv[0] <= r_dot_req;
                    r_pi[0] <= r_i;
                    r_pk[0] <= r_k;
                    for (int n = 1; n < DOT_LAT; n++) begin
                        r_pv[n] <= r_pv[n-1];
                        r_pi[n] <= r_pi[n-1];
                        r_pk[n] <= r_pk[n-1];
                    end
                end
            end

            assign w_ret_valid = r_pv[DOT_LAT-1];
            assign w_ret_i     = r_pi[DOT_LAT-1];
            assign w_ret_k     = r_pk[DOT_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_dot_req   <= 1'b0;
            r_out_valid <= 1'b0;
            r_lhs       <= '0;
            r_rhs       <= '0;
            r_out       <= '0;
            r_i         <= '0;
            r_k         <= '0;
        end else begin
            if (w_ret_valid) begin
                for (int r = 0; r < I; r++) begin
                    for (int c = 0; c < K; c++) begin
                        if (w_ret_i == IW'(r) && w_ret_k == KW'(c)) begin
                            r_out[(r*K + c)*W +: W] <= i_dot_res;
                        end
                    end
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_lhs      <= i_lhs;
                        r_rhs      <= i_rhs;
                        r_i        <= '0;
                        r_k        <= '0;
                        r_in_ready <= 1'b0;
                        r_dot_req  <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_k == K_LAST) begin
                        r_k <= '0;
                        r_i <= (r_i == I_LAST) ? '0 : r_i + IW'(1);
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                    if (w_issue_last) begin
                        r_dot_req <= 1'b0;
                        if (DOT_LAT == 0) begin
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_state     <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_ret_last) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef MAT_MUL_SEQ_CYCLE_CNT_EN
    // Starts at 1 in the first RUN cycle, frozen once the product is complete.
    logic [31:0] r_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycles <= '0;
        end else if (r_state == S_IDLE && i_in_valid) begin
            r_cycles <= 32'd1;
        end else if (r_state == S_RUN || r_state == S_DRAIN) begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign o_cycles = r_cycles;
`else
    assign o_cycles = '0;
`endif

    assign o_in_ready  = r_in_ready;
    assign o_dot_req   = r_dot_req;
    assign o_dot_lhs   = w_dot_lhs;
    assign o_dot_rhs   = w_dot_rhs;
    assign o_out_valid = r_out_valid;
    assign o_out       = r_out;

endmodule

// File: tb/tb_mat_mul_seq.sv
// Bench for mat_mul_seq: two instances (DOT_LAT 0 and 3), a float dot-unit model, and a
// spec-level timing/product model checked on every falling edge.
module tb_mat_mul_seq;
    localparam int W  = 32;
    localparam int I  = 2;
    localparam int J  = 2;
    localparam int K  = 2;
    localparam int IK = I * K;
    localparam logic [31:0]  JUNK  = 32'hDEADBEEF;
    localparam logic [127:0] IDENT = {32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000};
    localparam logic [127:0] R1234 = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    localparam logic [127:0] ALL1  = {4{32'h3F800000}};
    localparam logic [127:0] ALL2  = {4{32'h40000000}};
    localparam logic [127:0] ALL4  = {4{32'h40800000}};
    localparam logic [127:0] SQ    = {32'h41B00000, 32'h41700000, 32'h41200000, 32'h40E00000};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] lhs;
    logic [127:0] rhs;
    int           sel;
    int           lat;

    logic         in_ready0, dot_req0, out_valid0;
    logic [63:0]  dot_lhs0, dot_rhs0;
    logic [31:0]  dot_res0, cycles0;
    logic [127:0] out0;
    logic         in_ready3, dot_req3, out_valid3;
    logic [63:0]  dot_lhs3, dot_rhs3;
    logic [31:0]  dot_res3, cycles3;
    logic [127:0] out3;
    logic         in_valid0, in_valid3;

    assign in_valid0 = in_valid && (sel == 0);
    assign in_valid3 = in_valid && (sel == 1);

    mat_mul_seq #(.EXP_WIDTH(8), .MANT_WIDTH(23), .I(I), .J(J), .K(K), .DOT_LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid0), .o_in_ready(in_ready0),
        .i_lhs(lhs), .i_rhs(rhs), .o_dot_req(dot_req0), .o_dot_lhs(dot_lhs0),
        .o_dot_rhs(dot_rhs0), .i_dot_res(dot_res0), .o_out_valid(out_valid0),
        .i_out_ready(out_ready), .o_out(out0), .o_cycles(cycles0)
    );

    mat_mul_seq #(.EXP_WIDTH(8), .MANT_WIDTH(23), .I(I), .J(J), .K(K), .DOT_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid3), .o_in_ready(in_ready3),
        .i_lhs(lhs), .i_rhs(rhs), .o_dot_req(dot_req3), .o_dot_lhs(dot_lhs3),
        .o_dot_rhs(dot_rhs3), .i_dot_res(dot_res3), .o_out_valid(out_valid3),
        .i_out_ready(out_ready), .o_out(out3), .o_cycles(cycles3)
    );

    // Exact conversions for small non-negative integer-valued floats.
    function automatic int f2i(input logic [31:0] b);
        logic [23:0] m;
        int e;
        if (b[30:0] == 31'd0) return 0;
        e = int'(b[30:23]);
        m = {1'b1, b[22:0]};
        return int'(m >> (150 - e));
    endfunction

    function automatic logic [31:0] i2f(input int v);
        logic [31:0] t;
        int p;
        if (v == 0) return 32'd0;
        p = 0;
        for (int b = 0; b < 31; b++) if (v[b]) p = b;
        t = 32'(v) << (23 - p);
        return {1'b0, 8'(127 + p), t[22:0]};
    endfunction

    function automatic logic [31:0] fdot(input logic [63:0] a, input logic [63:0] b);
        int s;
        s = 0;
        for (int j = 0; j < J; j++) s += f2i(a[j*W +: W]) * f2i(b[j*W +: W]);
        return i2f(s);
    endfunction

    function automatic logic [127:0] matmul(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] r;
        int s;
        r = '0;
        for (int i = 0; i < I; i++) begin
            for (int k = 0; k < K; k++) begin
                s = 0;
                for (int j = 0; j < J; j++) s += f2i(a[(i*J + j)*W +: W]) * f2i(b[(j*K + k)*W +: W]);
                r[(i*K + k)*W +: W] = i2f(s);
            end
        end
        return r;
    endfunction

    // External dot units: combinational for DUT 0, three-stage pipe for DUT 3.
    logic [31:0] p3_0 = JUNK, p3_1 = JUNK, p3_2 = JUNK;
    always_comb dot_res0 = dot_req0 ? fdot(dot_lhs0, dot_rhs0) : JUNK;
    always @(posedge clk) begin
        p3_0 <= dot_req3 ? fdot(dot_lhs3, dot_rhs3) : JUNK;
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end
    assign dot_res3 = p3_2;

    logic         c_in_ready, c_dot_req, c_out_valid;
    logic [63:0]  c_dot_lhs, c_dot_rhs;
    logic [127:0] c_out;
    logic [31:0]  c_cycles;
    assign c_in_ready  = (sel == 1) ? in_ready3  : in_ready0;
    assign c_dot_req   = (sel == 1) ? dot_req3   : dot_req0;
    assign c_out_valid = (sel == 1) ? out_valid3 : out_valid0;
    assign c_dot_lhs   = (sel == 1) ? dot_lhs3   : dot_lhs0;
    assign c_dot_rhs   = (sel == 1) ? dot_rhs3   : dot_rhs0;
    assign c_out       = (sel == 1) ? out3       : out0;
    assign c_cycles    = (sel == 1) ? cycles3    : cycles0;

    // Job model: idle/busy, accept cycle, operands, product and what out must hold when idle.
    int           cyc = 0;
    logic         m_busy = 1'b0;
    int           m_T = 0;
    logic [127:0] m_lhs = '0, m_rhs = '0, m_exp = '0, m_out = '0;
    logic [31:0]  m_cyc = '0;
    logic [127:0] lit_out = '0;
    int           lit_off = 5;
    logic [31:0]  lit_cyc = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_out  <= '0;
            m_cyc  <= '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_T    <= cyc;
                m_lhs  <= lhs;
                m_rhs  <= rhs;
                m_exp  <= matmul(lhs, rhs);
            end
        end else if ((cyc - m_T - 1 >= IK + lat) && out_ready) begin
            m_busy <= 1'b0;
            m_out  <= m_exp;
`ifdef MAT_MUL_SEQ_CYCLE_CNT_EN
            m_cyc  <= 32'(1 + IK + lat);
`else
            m_cyc  <= '0;
`endif
        end
        cyc <= cyc + 1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d, lat %0d)", name, act, exp, cyc, lat);
        end
    endtask

    always @(negedge clk) begin
        int           n;
        logic         e_ready, e_req, e_ov, chk_out;
        logic [63:0]  e_lhs, e_rhs;
        logic [127:0] e_out;
        logic [31:0]  e_cyc;
        e_ready = 1'b1; e_req = 1'b0; e_ov = 1'b0; chk_out = 1'b1;
        e_lhs = '0; e_rhs = '0; e_out = m_out; e_cyc = m_cyc;
        if (!rst_n) begin
            e_out = '0;
            e_cyc = '0;
        end else if (m_busy) begin
            n       = cyc - m_T - 1;
            e_ready = 1'b0;
            e_req   = (n >= 0) && (n < IK);
            e_ov    = (n >= IK + lat);
            chk_out = e_ov;
            e_out   = m_exp;
`ifdef MAT_MUL_SEQ_CYCLE_CNT_EN
            e_cyc   = e_ov ? 32'(1 + IK + lat) : 32'(n + 1);
`else
            e_cyc   = '0;
`endif
            if (e_req) begin
                for (int j = 0; j < J; j++) begin
                    e_lhs[j*W +: W] = m_lhs[((n / K)*J + j)*W +: W];
                    e_rhs[j*W +: W] = m_rhs[(j*K + (n % K))*W +: W];
                end
            end
        end
        check("in_ready",  128'(c_in_ready),  128'(e_ready));
        check("dot_req",   128'(c_dot_req),   128'(e_req));
        check("dot_lhs",   128'(c_dot_lhs),   128'(e_lhs));
        check("dot_rhs",   128'(c_dot_rhs),   128'(e_rhs));
        check("out_valid", 128'(c_out_valid), 128'(e_ov));
        check("cycles",    128'(c_cycles),    128'(e_cyc));
        if (chk_out) check("out", c_out, e_out);
        if (rst_n && m_busy && (cyc - m_T == lit_off)) begin
            check("lit_out_valid", 128'(c_out_valid), 128'(1'b1));
            check("lit_out",       c_out,             lit_out);
            check("lit_cycles",    128'(c_cycles),    128'(lit_cyc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [127:0] a, input logic [127:0] b, input logic [127:0] lit);
        lhs      = a;
        rhs      = b;
        lit_out  = lit;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_job(input logic [127:0] a, input logic [127:0] b, input logic [127:0] lit);
        start(a, b, lit);
        repeat (IK + lat + 1) tick();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        lhs = '0; rhs = '0; sel = 0; lat = 0;
        for (int s = 0; s < 2; s++) begin
            rst_n   = 1'b0;
            sel     = s;
            lat     = (s == 1) ? 3 : 0;
            lit_off = (s == 1) ? 8 : 5;
`ifdef MAT_MUL_SEQ_CYCLE_CNT_EN
            lit_cyc = (s == 1) ? 32'd8 : 32'd5;
`else
            lit_cyc = 32'd0;
`endif
            tick(); tick();
            rst_n = 1'b1;
            tick();
            $display("lat %0d: identity x {1,2;3,4}", lat);
            run_job(IDENT, R1234, R1234);
            $display("lat %0d: all 2.0 x all 1.0", lat);
            run_job(ALL2, ALL1, ALL4);
            $display("lat %0d: {1,2;3,4}^2 with out_ready held low", lat);
            out_ready = 1'b0;
            start(R1234, R1234, SQ);
            repeat (IK + lat) tick();
            tick();
            lhs = ALL2; rhs = ALL2; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            repeat (3) tick();
            out_ready = 1'b1;
            tick();
            $display("lat %0d: back-to-back identity job", lat);
            run_job(IDENT, R1234, R1234);
            $display("lat %0d: reset during issue 2", lat);
            start(ALL2, ALL1, ALL4);
            tick();
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            repeat (5) tick();
            $display("lat %0d: job after reset", lat);
            run_job(ALL2, ALL1, ALL4);
        end
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mat_mul_seq.md
# mat_mul_seq

Time-multiplexed matrix-multiply sequencer: accepts an I×J lhs and a J×K rhs, latches both, then drives one shared dot-product unit once per output element (I·K issues) and assembles the I×K product in an output register. Trades the fully parallel array for one dot unit plus this controller. The dot unit sits outside the block and may be pipelined by a fixed latency.

## Interface
- EXP_WIDTH, 8, float exponent width.
- MANT_WIDTH, 23, float mantissa width; element width W = 1+EXP_WIDTH+MANT_WIDTH.
- I, 4, lhs rows / out rows (≥1).
- J, 4, inner dimension (≥1).
- K, 4, rhs columns / out columns (≥1).
- DOT_LAT, 0, dot unit latency in cycles (0 = combinational result in issue cycle).

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands offered.
- in_ready  out  1  block idle, will accept.
- lhs  in  I·J·W  element (r,c) at bits [(r·J+c)·W +: W].
- rhs  in  J·K·W  element (r,c) at [(r·K+c)·W +: W].
- dot_req  out  1  issue to dot unit this cycle.
- dot_lhs  out  J·W  row i of latched lhs; element j at [j·W +: W].
- dot_rhs  out  J·W  column k of latched rhs; element j at [j·W +: W].
- dot_res  in  W  dot result, valid DOT_LAT cycles after its issue.
- out_valid  out  1  product complete.
- out_ready  in  1  consumer takes product.
- out  out  I·K·W  product, element (i,k) at [(i·K+k)·W +: W].
- cycles  out  32  job cycle count (see Configuration).

## Operation
- States: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE: in_ready=1. in_valid&in_ready latches lhs, rhs; clears i,k; → RUN.
- RUN: dot_req=1, dot_lhs/dot_rhs gathered from latched operands at (i,k). k increments each cycle, wraps to 0 at K−1 with i+1. After issue (I−1,K−1): → DRAIN if DOT_LAT>0, else → DONE.
- Retire: a DOT_LAT-deep valid/index pipeline tracks issues; when an entry emerges, dot_res is written to out element (i,k) of that issue. DOT_LAT=0: written at end of issue cycle.
- DRAIN: no issue; → DONE when last result is written.
- DONE: out_valid=1, out stable. out_valid&out_ready → IDLE.
- dot_lhs, dot_rhs = 0 whenever dot_req=0.
- out keeps the last product after handoff; overwritten element by element in the next job. No arithmetic in this block; dot_res is stored bit-exact.
- in_valid while not IDLE: ignored, no latch.

## Timing
- Reset (async, any state, incl. mid-RUN/DRAIN): state IDLE, in_ready=1, dot_req=0, dot_lhs=dot_rhs=0, out_valid=0, out=0, cycles=0; pipeline flushed, in-flight results discarded.
- Accept at cycle T: issues in cycles T+1 … T+I·K, one per cycle, row-major (k fastest).
- out_valid first high at cycle T+1+I·K+DOT_LAT.
- out_ready low: hold DONE indefinitely, out/out_valid stable, in_ready=0.
- Handoff at cycle D: in_ready=1 from D+1; earliest next accept D+1.
- I=K=1: single issue, RUN lasts one cycle.

## Configuration
- MAT_MUL_SEQ_CYCLE_CNT_EN defined: cycles counts from accept cycle (value 1 in T+1) and freezes when out_valid rises, so it reads 1+I·K+DOT_LAT in DONE; held until next accept, then restarts.
- Undefined: cycles tied to 0, no counter logic.

## Test plan
- I=J=K=2, DOT_LAT=0, behavioural dot model; lhs=identity (3F800000 diag, 0 off), rhs={1.0,2.0;3.0,4.0} → out = rhs bit-exact, out_valid at T+5, cycles=5 (macro on).
- Same operands, DOT_LAT=3 → identical out, out_valid at T+8, dot_req high exactly cycles T+1..T+4, cycles=8.
- lhs=all 2.0 (40000000), rhs=all 1.0, I=J=K=2 → every out element 40800000 (4.0); issue order (0,0),(0,1),(1,0),(1,1) checked on dot_lhs/dot_rhs.
- out_ready held low 5 cycles in DONE, in_valid pulsed → out unchanged, in_ready=0, no relatch; then handoff → in_ready=1 next cycle, second job back-to-back completes correctly.
- rst_n low during RUN (issue 2 of 4), DOT_LAT=3 → all outputs at reset values immediately; after release new job gives correct out, no stale results written.
- Macro undefined build → cycles=0 throughout, function unchanged.
